// File: rtl/cube_scan_ctrl.sv
// cube_scan_ctrl: layer-multiplexed scan controller for the 8x8x8 LED cube.
// Double-buffers incoming 512-bit frames (shadow/display) and swaps only at a
// full-scan boundary, so a frame is never shown partially. Each layer is
// preceded by a blanking gap to suppress ghosting.
// Optional build macro: CUBE_SCAN_PWM_EN adds brightness[3:0] and gates
// col_data with a 4-bit PWM counter during SHOW.
//
// state | meaning
// IDLE  | not scanning, all outputs off, waiting for scan_en and a frame
// BLANK | inter-layer gap, drivers off, dwell BLANK_TICKS cycles
// SHOW  | layer cur_layer lit with its column slice, dwell LAYER_TICKS cycles
module cube_scan_ctrl #(
   parameter int LAYER_TICKS = 12500,
   parameter int BLANK_TICKS = 100,
   parameter int CNT_W       = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [511:0] frame_cube_flat,
   input  logic         frame_valid,
   input  logic         scan_en,
`ifdef CUBE_SCAN_PWM_EN
   input  logic [3:0]   brightness,
`endif
   output logic [7:0]   layer_sel,
   output logic [63:0]  col_data,
   output logic [2:0]   cur_layer,
   output logic         frame_start,
   output logic         frame_dropped,
   output logic         active
);

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

   localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_TICKS - 1);
   localparam logic [CNT_W-1:0] LAYER_LOAD = CNT_W'(LAYER_TICKS - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [511:0]     shadow;
   logic [511:0]     display;
   logic             pending;
   logic             loaded;
   logic             swap;
   logic [63:0]      slice;
   logic [63:0]      show_first;
   logic [63:0]      show_next;

`ifdef CUBE_SCAN_PWM_EN
   logic [3:0]       pwm_cnt;
`endif

   assign slice = display[{cur_layer, 6'd0} +: 64];

   // Swap happens when a scan (re)starts with a frame waiting, or at the wrap.
   always_comb begin
      swap = 1'b0;
      case (state)
         IDLE:    swap = scan_en && pending;
         SHOW:    swap = scan_en && (cnt == '0) && (cur_layer == 3'd7) && pending;
         default: swap = 1'b0;
      endcase
   end

   // Column data for the first SHOW cycle and for subsequent SHOW cycles.
   always_comb begin
`ifdef CUBE_SCAN_PWM_EN
      show_first = (4'd0 < brightness) ? slice : 64'd0;
      show_next  = ((pwm_cnt + 4'd1) < brightness) ? slice : 64'd0;
`else
      show_first = slice;
      show_next  = slice;
`endif
   end

   // Shadow/display buffering; the swap reads the old shadow before capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow        <= '0;
         display       <= '0;
         pending       <= 1'b0;
         loaded        <= 1'b0;
         frame_dropped <= 1'b0;
      end else begin
         frame_dropped <= frame_valid && pending && !swap;
         if (swap) begin
            display <= shadow;
            loaded  <= 1'b1;
         end
         if (frame_valid) begin
            shadow  <= frame_cube_flat;
            pending <= 1'b1;
         end else if (swap) begin
            pending <= 1'b0;
         end
      end
   end

   // Scan FSM with registered drive outputs and down-counting dwell timer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         cur_layer   <= 3'd0;
         layer_sel   <= 8'd0;
         col_data    <= 64'd0;
         active      <= 1'b0;
         frame_start <= 1'b0;
`ifdef CUBE_SCAN_PWM_EN
         pwm_cnt     <= 4'd0;
`endif
      end else begin
         frame_start <= swap;
         case (state)
            IDLE: begin
               if (scan_en && (pending || loaded)) begin
                  state     <= BLANK;
                  cnt       <= BLANK_LOAD;
                  cur_layer <= 3'd0;
                  active    <= 1'b1;
               end
            end
            BLANK: begin
               if (!scan_en) begin
                  state     <= IDLE;
                  cnt       <= '0;
                  cur_layer <= 3'd0;
                  active    <= 1'b0;
               end else if (cnt == '0) begin
                  state     <= SHOW;
                  cnt       <= LAYER_LOAD;
                  layer_sel <= 8'd1 << cur_layer;
                  col_data  <= show_first;
`ifdef CUBE_SCAN_PWM_EN
                  pwm_cnt   <= 4'd0;
`endif
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            SHOW: begin
               if (!scan_en) begin
                  state     <= IDLE;
                  cnt       <= '0;
                  cur_layer <= 3'd0;
                  layer_sel <= 8'd0;
                  col_data  <= 64'd0;
                  active    <= 1'b0;
               end else if (cnt == '0) begin
                  // cur_layer wraps 7 -> 0 naturally in 3 bits
                  state     <= BLANK;
                  cnt       <= BLANK_LOAD;
                  cur_layer <= cur_layer + 3'd1;
                  layer_sel <= 8'd0;
                  col_data  <= 64'd0;
               end else begin
                  cnt      <= cnt - 1'b1;
                  col_data <= show_next;
`ifdef CUBE_SCAN_PWM_EN
                  pwm_cnt  <= pwm_cnt + 4'd1;
`endif
               end
            end
            default: begin
               state     <= IDLE;
               cnt       <= '0;
               cur_layer <= 3'd0;
               layer_sel <= 8'd0;
               col_data  <= 64'd0;
               active    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cube_scan_ctrl.sv
// Testbench for cube_scan_ctrl. A reference model tracks the scan as a
// position within the frame period and pushes the expected output vector per
// cycle into a queue; a monitor pops and compares after every clock edge.
module tb_cube_scan_ctrl;
   localparam int LT   = 4;
   localparam int BT   = 2;
   localparam int PER  = LT + BT;
   localparam int FPER = 8 * PER;

   logic         clk = 1'b1;
   logic         rst = 1'b1;
   logic [511:0] frame_cube_flat = '0;
   logic         frame_valid = 1'b0;
   logic         scan_en = 1'b0;
`ifdef CUBE_SCAN_PWM_EN
   logic [3:0]   brightness = 4'd15;
`endif
   logic [7:0]   layer_sel;
   logic [63:0]  col_data;
   logic [2:0]   cur_layer;
   logic         frame_start;
   logic         frame_dropped;
   logic         active;

   cube_scan_ctrl #(.LAYER_TICKS(LT), .BLANK_TICKS(BT), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .frame_cube_flat(frame_cube_flat),
      .frame_valid(frame_valid), .scan_en(scan_en),
`ifdef CUBE_SCAN_PWM_EN
      .brightness(brightness),
`endif
      .layer_sel(layer_sel), .col_data(col_data), .cur_layer(cur_layer),
      .frame_start(frame_start), .frame_dropped(frame_dropped), .active(active)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  ls;
      logic [63:0] cd;
      logic [2:0]  cl;
      logic        fs;
      logic        fd;
      logic        act;
   } out_t;

   out_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_fs    = 0;
   int   n_fd    = 0;

   // reference model
   logic [511:0] m_shadow, m_display;
   bit           m_pend, m_loaded, m_run;
   int           m_t;

   function automatic out_t actual();
      out_t a;
      a.ls = layer_sel; a.cd = col_data; a.cl = cur_layer;
      a.fs = frame_start; a.fd = frame_dropped; a.act = active;
      return a;
   endfunction

   function automatic logic [511:0] rand_frame();
      logic [511:0] f;
      for (int i = 0; i < 16; i++) f[32*i +: 32] = $urandom;
      return f;
   endfunction

   // monitor: one comparison per clock edge
   initial begin
      out_t e, a;
      forever begin
         @(posedge clk);
         #1;
         a = actual();
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty t=%0t actual=%h", $time, a);
         end else begin
            e = exp_q.pop_front();
            if (a.fs) n_fs++;
            if (a.fd) n_fd++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL outputs t=%0t actual ls=%h cd=%h cl=%0d fs=%b fd=%b act=%b required ls=%h cd=%h cl=%0d fs=%b fd=%b act=%b",
                        $time, a.ls, a.cd, a.cl, a.fs, a.fd, a.act,
                        e.ls, e.cd, e.cl, e.fs, e.fd, e.act);
            end
         end
      end
   end

   // One clock of stimulus plus the model's prediction of the next output.
   task automatic cycle(input bit fv, input logic [511:0] f, input bit en, input bit r);
      out_t e;
      bit   sw, show;
      int   ph, lay;
      sw = 1'b0;
      @(negedge clk);
      rst = r; frame_valid = fv; frame_cube_flat = f; scan_en = en;
      e = '0;
      if (r) begin
         m_shadow = '0; m_display = '0; m_pend = 0; m_loaded = 0; m_run = 0; m_t = 0;
         #1;
         n_tests++;
         if (actual() !== out_t'(0)) begin
            n_fail++;
            $display("FAIL async_reset t=%0t actual=%h required=0", $time, actual());
         end
      end else begin
         if (!m_run) begin
            if (en && (m_pend || m_loaded)) begin
               m_run = 1; m_t = 0; sw = m_pend;
            end
         end else if (!en) begin
            m_run = 0; m_t = 0;
         end else begin
            m_t++;
            if (m_t == FPER) begin
               m_t = 0; sw = m_pend;
            end
         end
         if (sw) begin
            m_display = m_shadow; m_loaded = 1; m_pend = 0; e.fs = 1'b1;
         end
         if (fv) begin
            e.fd = m_pend; m_shadow = f; m_pend = 1;
         end
         ph = m_t % PER;
         lay = m_t / PER;
         show = m_run && (ph >= BT);
         e.act = m_run;
         e.cl = m_run ? 3'(lay) : 3'd0;
         if (show) begin
            e.ls = 8'(1 << lay);
            e.cd = m_display[64*lay +: 64];
`ifdef CUBE_SCAN_PWM_EN
            if (((ph - BT) % 16) >= int'(brightness)) e.cd = 64'd0;
`endif
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic run_to(input int target);
      for (int i = 0; i < 400 && !(m_run && m_t == target); i++)
         cycle(1'b0, rand_frame(), 1'b1, 1'b0);
      n_tests++;
      if (!(m_run && m_t == target)) begin
         n_fail++;
         $display("FAIL run_to_bound actual_pos=%0d required_pos=%0d", m_t, target);
      end
   endtask

   initial begin
      logic [511:0] f1;
      int fs_before, fd_before;
      m_shadow = '0; m_display = '0; m_pend = 0; m_loaded = 0; m_run = 0; m_t = 0;
      for (int i = 0; i < 64; i++) f1[8*i +: 8] = 8'(i);

      // reset, then byte-ramp frame and two full scans
      cycle(0, '0, 0, 1);
      cycle(0, '0, 0, 1);
      for (int i = 0; i < 3; i++) cycle(0, rand_frame(), 1, 0);
      cycle(1, f1, 1, 0);
      for (int i = 0; i < 2 * FPER + 4; i++) cycle(0, rand_frame(), 1, 0);

      // frame A in layer 3, frame B in layer 5 -> one drop, B shown after wrap
      fd_before = n_fd;
      run_to(3 * PER + BT);
      cycle(1, rand_frame(), 1, 0);
      run_to(5 * PER + BT);
      cycle(1, rand_frame(), 1, 0);
      for (int i = 0; i < FPER; i++) cycle(0, rand_frame(), 1, 0);
      n_tests++;
      if (n_fd - fd_before != 1) begin
         n_fail++;
         $display("FAIL drop_count actual=%0d required=1", n_fd - fd_before);
      end

      // frame on the same cycle as the layer-7 SHOW exit
      run_to(FPER - 1);
      cycle(1, rand_frame(), 1, 0);
      for (int i = 0; i < 2 * FPER; i++) cycle(0, rand_frame(), 1, 0);

      // scan_en low for 10 cycles mid layer 4, then resume with no frame_start
      run_to(4 * PER + BT + 1);
      for (int i = 0; i < 10; i++) cycle(0, rand_frame(), 0, 0);
      fs_before = n_fs;
      for (int i = 0; i < FPER + 3; i++) cycle(0, rand_frame(), 1, 0);
      n_tests++;
      if (n_fs != fs_before) begin
         n_fail++;
         $display("FAIL resume_frame_start actual=%0d required=0", n_fs - fs_before);
      end

      // reset during SHOW; stays idle until a new frame
      run_to(2 * PER + BT + 1);
      cycle(0, rand_frame(), 1, 1);
      for (int i = 0; i < 20; i++) cycle(0, rand_frame(), 1, 0);
      cycle(1, rand_frame(), 1, 0);
      for (int i = 0; i < FPER; i++) cycle(0, rand_frame(), 1, 0);

`ifdef CUBE_SCAN_PWM_EN
      brightness = 4'd4;
      for (int i = 0; i < FPER; i++) cycle(0, rand_frame(), 1, 0);
      brightness = 4'd0;
      for (int i = 0; i < FPER; i++) cycle(0, rand_frame(), 1, 0);
`endif

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
`ifdef CUBE_SCAN_PWM_EN
         if ($urandom_range(0, 99) == 0) brightness = 4'($urandom);
`endif
         cycle($urandom_range(0, 24) == 0, rand_frame(),
               $urandom_range(0, 39) != 0, $urandom_range(0, 399) == 0);
      end

      @(posedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
